// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared word type and LC-3 memory-mapped I/O addresses.
package lc3_mem_pkg;
    typedef logic [15:0] word_t;
    localparam word_t MMIO_BASE = 16'hFE00;
    localparam word_t ADDR_KBSR = 16'hFE00;
    localparam word_t ADDR_KBDR = 16'hFE02;
    localparam word_t ADDR_DSR  = 16'hFE04;
    localparam word_t ADDR_DDR  = 16'hFE06;
    localparam word_t ADDR_MCR  = 16'hFFFE;
endpackage

// File: rtl/lc3_ram.sv
// lc3_ram: single-port synchronous RAM; rdata updates only on reads.
module lc3_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) r_mem[addr] <= wdata;
        if (en && !we) rdata <= r_mem[addr];
    end
endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: LC-3 memory port responder with RAM and KBSR/KBDR/DSR/DDR/MCR MMIO.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_en,
    input  logic              i_we,
    input  logic [15:0]       i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_kbd_valid,
    input  logic [7:0]        i_kbd_char,
    output logic              o_kbd_ready,
    output logic              o_kbd_irq,
    output logic              o_disp_valid,
    output logic [7:0]        o_disp_char,
    input  logic              i_disp_ready,
    output logic              o_halted
);
    logic        w_mmio, w_ram_sel, w_rd, w_wr;
    logic [15:0] w_mmio_rdata;
    logic [15:0] w_ram_rdata;
    logic [15:0] r_rdata;
    logic        r_src_ram;
    logic        r_kbsr_rdy, r_kbsr_ie, r_dsr_rdy, r_dsr_ie, r_mcr_run;
    logic [7:0]  r_kbdr;
    logic [15:0] r_ddr;

    assign w_mmio    = i_addr >= MMIO_BASE;
    assign w_ram_sel = !w_mmio && ((i_addr >> ADDR_W) == 16'h0);
    assign w_rd      = i_mem_en && !i_we;
    assign w_wr      = i_mem_en && i_we;

    lc3_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .en    (i_mem_en && w_ram_sel),
        .we    (i_we),
        .addr  (i_addr[ADDR_W-1:0]),
        .wdata (i_data),
        .rdata (w_ram_rdata)
    );

    // Unmapped addresses and unused MMIO slots fall through to zero.
    always_comb
        w_mmio_rdata = !w_mmio               ? 16'h0 :
                       i_addr == ADDR_KBSR   ? {r_kbsr_rdy, r_kbsr_ie, 14'h0} :
                       i_addr == ADDR_KBDR   ? {8'h0, r_kbdr} :
                       i_addr == ADDR_DSR    ? {r_dsr_rdy, r_dsr_ie, 14'h0} :
                       i_addr == ADDR_DDR    ? r_ddr :
                       i_addr == ADDR_MCR    ? {r_mcr_run, 15'h0} : 16'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata      <= '0;
            r_src_ram    <= 1'b0;
            r_kbsr_rdy   <= 1'b0;
            r_kbsr_ie    <= 1'b0;
            r_kbdr       <= '0;
            r_dsr_rdy    <= 1'b1;
            r_dsr_ie     <= 1'b0;
            r_ddr        <= '0;
            r_mcr_run    <= 1'b1;
            o_disp_valid <= 1'b0;
            o_disp_char  <= '0;
        end else begin
            if (w_rd) begin
                r_src_ram <= w_ram_sel;
                if (!w_ram_sel) r_rdata <= w_mmio_rdata;
            end
            if (i_kbd_valid && !r_kbsr_rdy) begin
                r_kbdr     <= i_kbd_char;
                r_kbsr_rdy <= 1'b1;
            end else if (w_rd && i_addr == ADDR_KBDR) r_kbsr_rdy <= 1'b0;
            if (w_wr && i_addr == ADDR_KBSR) r_kbsr_ie <= i_data[14];
            if (w_wr && i_addr == ADDR_DSR) r_dsr_ie <= i_data[14];
            // DSR ready and disp_valid are complementary, so these branches never collide.
            if (w_wr && i_addr == ADDR_DDR && r_dsr_rdy) begin
                r_ddr        <= i_data;
                o_disp_char  <= i_data[7:0];
                o_disp_valid <= 1'b1;
                r_dsr_rdy    <= 1'b0;
            end else if (o_disp_valid && i_disp_ready) begin
                o_disp_valid <= 1'b0;
                r_dsr_rdy    <= 1'b1;
            end
            if (w_wr && i_addr == ADDR_MCR) r_mcr_run <= i_data[15];
        end
    end

    assign o_rdata     = r_src_ram ? w_ram_rdata : r_rdata;
    assign o_kbd_ready = !r_kbsr_rdy;
    assign o_kbd_irq   = r_kbsr_rdy && r_kbsr_ie;
    assign o_halted    = !r_mcr_run;
endmodule
